// File: rtl/writeback_unit_if.sv
// Bundle of the writeback unit's result inputs, scoreboard and register-file write port.
// The slave modport belongs to the writeback unit; the master side drives results and issue.
interface writeback_unit_if;
  logic        alu_valid;
  logic [3:0]  alu_rd;
  logic [18:0] alu_data;
  logic        long_valid;
  logic        long_ready;
  logic [3:0]  long_rd;
  logic [18:0] long_data;
  logic        issue_long;
  logic [3:0]  issue_rd;
  logic [15:0] busy;
  logic [3:0]  rf_rd;
  logic [18:0] rf_write_data;
  logic        rf_regwrite;
  logic        fwd_valid;
  logic [3:0]  fwd_rd;
  logic [18:0] fwd_data;

  modport master (
    output alu_valid, alu_rd, alu_data, long_valid, long_rd, long_data, issue_long, issue_rd,
    input  long_ready, busy, rf_rd, rf_write_data, rf_regwrite, fwd_valid, fwd_rd, fwd_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, long_valid, long_rd, long_data, issue_long, issue_rd,
    output long_ready, busy, rf_rd, rf_write_data, rf_regwrite, fwd_valid, fwd_rd, fwd_data
  );
endinterface

// File: rtl/writeback_unit.sv
// Final pipeline stage: merges ALU and buffered multi-cycle results onto the single
// register-file write port and tracks long-latency destinations in a busy scoreboard.
module writeback_unit #(
  parameter int unsigned DEPTH = 2
) (
  input logic            clk,
  input logic            reset,
  writeback_unit_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [3:0]      fifo_rd_q   [DEPTH];
  logic [18:0]     fifo_data_q [DEPTH];

  logic [15:0] busy_q, busy_d;
  logic        rf_we_q, rf_we_d;
  logic [3:0]  rf_rd_q, rf_rd_d;
  logic [18:0] rf_data_q, rf_data_d;

  logic alu_take, accept, push, pop, ready;

  // Ready looks only at registered count, so a pop never frees space in the same cycle.
  assign ready    = (count_q != CntW'(DEPTH));
  assign alu_take = bus.alu_valid && (bus.alu_rd != 4'd0);
  assign accept   = bus.long_valid && ready;
  assign push     = accept && (bus.long_rd != 4'd0);
  assign pop      = !alu_take && (count_q != '0);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    busy_d    = busy_q;
    rf_we_d   = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;

    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (alu_take) begin
      rf_we_d   = 1'b1;
      rf_rd_d   = bus.alu_rd;
      rf_data_d = bus.alu_data;
    end else if (pop) begin
      rf_we_d   = 1'b1;
      rf_rd_d   = fifo_rd_q[rd_ptr_q];
      rf_data_d = fifo_data_q[rd_ptr_q];
    end

    // Clear first so a same-cycle issue to the retiring register keeps it busy.
    if (pop) busy_d[fifo_rd_q[rd_ptr_q]] = 1'b0;
    if (bus.issue_long && (bus.issue_rd != 4'd0)) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      busy_q    <= '0;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= bus.long_rd;
      fifo_data_q[wr_ptr_q] <= bus.long_data;
    end
  end

  assign bus.long_ready    = ready;
  assign bus.busy          = busy_q;
  assign bus.rf_regwrite   = rf_we_q;
  assign bus.rf_rd         = rf_rd_q;
  assign bus.rf_write_data = rf_data_q;
  assign bus.fwd_valid     = rf_we_q;
  assign bus.fwd_rd        = rf_rd_q;
  assign bus.fwd_data      = rf_data_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed and random stimulus for writeback_unit, checked against a queue-based model
// of pending long results and a per-register busy table.
module tb_writeback_unit;
  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  writeback_unit_if bus ();

  writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad = 0;

  // Model: pending long results in acceptance order, plus the expected write port.
  logic [22:0] m_q [$];
  logic        m_busy [16];
  logic        m_we;
  logic [3:0]  m_rd;
  logic [18:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_busy_vec();
    logic [15:0] v;
    for (int r = 0; r < 16; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic model_clear();
    m_q.delete();
    for (int r = 0; r < 16; r++) m_busy[r] = 1'b0;
    m_we = 1'b0;
  endtask

  task automatic check_all();
    chk("rf_regwrite", {31'd0, bus.rf_regwrite}, {31'd0, m_we});
    chk("fwd_valid", {31'd0, bus.fwd_valid}, {31'd0, m_we});
    if (m_we) begin
      chk("rf_rd", {28'd0, bus.rf_rd}, {28'd0, m_rd});
      chk("rf_write_data", {13'd0, bus.rf_write_data}, {13'd0, m_data});
      chk("fwd_rd", {28'd0, bus.fwd_rd}, {28'd0, m_rd});
      chk("fwd_data", {13'd0, bus.fwd_data}, {13'd0, m_data});
    end
    chk("busy", {16'd0, bus.busy}, {16'd0, m_busy_vec()});
    chk("long_ready", {31'd0, bus.long_ready}, {31'd0, m_q.size() < DEPTH});
  endtask

  // One clock: drive inputs, advance the model at the edge, then compare after the edge.
  task automatic cyc(input logic av, input logic [3:0] ar, input logic [18:0] ad,
                     input logic lv, input logic [3:0] lr, input logic [18:0] ld,
                     input logic il, input logic [3:0] ir);
    logic room;
    logic [22:0] head;
    bus.alu_valid  = av;
    bus.alu_rd     = ar;
    bus.alu_data   = ad;
    bus.long_valid = lv;
    bus.long_rd    = lr;
    bus.long_data  = ld;
    bus.issue_long = il;
    bus.issue_rd   = ir;
    @(posedge clk);
    room = (m_q.size() < DEPTH);
    if (av && ar != 0) begin
      m_we = 1'b1; m_rd = ar; m_data = ad;
    end else if (m_q.size() > 0) begin
      head = m_q.pop_front();
      m_we = 1'b1; m_rd = head[22:19]; m_data = head[18:0];
      m_busy[head[22:19]] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (lv && room && lr != 0) m_q.push_back({lr, ld});
    if (il && ir != 0) m_busy[ir] = 1'b1;
    #1;
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 19'd0, 1'b0, 4'd0, 19'd0, 1'b0, 4'd0);
  endtask

  initial begin
    logic [3:0] ir;
    logic       il;
    model_clear();
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.long_valid = 0; bus.long_rd = 0; bus.long_data = 0;
    bus.issue_long = 0; bus.issue_rd = 0;

    // Reset values, including ready while reset is held.
    #1;
    chk("rst_regwrite", {31'd0, bus.rf_regwrite}, 32'd0);
    chk("rst_rd", {28'd0, bus.rf_rd}, 32'd0);
    chk("rst_data", {13'd0, bus.rf_write_data}, 32'd0);
    chk("rst_busy", {16'd0, bus.busy}, 32'd0);
    chk("rst_ready", {31'd0, bus.long_ready}, 32'd1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // ALU latency of one cycle.
    cyc(1'b1, 4'd5, 19'h12345, 1'b0, 4'd0, 19'd0, 1'b0, 4'd0);
    chk("alu_n1_rd", {28'd0, bus.rf_rd}, 32'd5);
    idle();
    chk("alu_n2_we", {31'd0, bus.rf_regwrite}, 32'd0);

    // Scoreboard set and clear on writeback.
    cyc(1'b0, 4'd0, 19'd0, 1'b0, 4'd0, 19'd0, 1'b1, 4'd3);
    chk("busy_r3", {16'd0, bus.busy}, 32'h0008);
    cyc(1'b0, 4'd0, 19'd0, 1'b1, 4'd3, 19'h7FFFF, 1'b0, 4'd0);
    idle();
    chk("long_r3_data", {13'd0, bus.rf_write_data}, 32'h7FFFF);
    chk("busy_r3_clr", {16'd0, bus.busy}, 32'h0000);
    idle();

    // FIFO fills behind a held ALU stream, then drains in order.
    cyc(1'b1, 4'd4, 19'h00040, 1'b1, 4'd1, 19'h11111, 1'b0, 4'd0);
    cyc(1'b1, 4'd4, 19'h00041, 1'b1, 4'd2, 19'h22222, 1'b0, 4'd0);
    chk("full_ready", {31'd0, bus.long_ready}, 32'd0);
    cyc(1'b1, 4'd4, 19'h00042, 1'b1, 4'd9, 19'h33333, 1'b0, 4'd0);
    cyc(1'b1, 4'd4, 19'h00043, 1'b0, 4'd0, 19'd0, 1'b0, 4'd0);
    idle();
    chk("drain_r1", {28'd0, bus.rf_rd}, 32'd1);
    idle();
    chk("drain_r2", {28'd0, bus.rf_rd}, 32'd2);
    idle();

    // ALU rd0 does not block the head; long rd0 is never written.
    cyc(1'b0, 4'd0, 19'd0, 1'b1, 4'd6, 19'h06060, 1'b0, 4'd0);
    cyc(1'b1, 4'd0, 19'h55555, 1'b0, 4'd0, 19'd0, 1'b0, 4'd0);
    chk("r6_past_rd0", {28'd0, bus.rf_rd}, 32'd6);
    cyc(1'b0, 4'd0, 19'd0, 1'b1, 4'd0, 19'h00BAD, 1'b0, 4'd0);
    idle();
    idle();

    // Same-cycle set and clear of r7: the set wins.
    cyc(1'b0, 4'd0, 19'd0, 1'b0, 4'd0, 19'd0, 1'b1, 4'd7);
    cyc(1'b0, 4'd0, 19'd0, 1'b1, 4'd7, 19'h07070, 1'b0, 4'd0);
    cyc(1'b0, 4'd0, 19'd0, 1'b0, 4'd0, 19'd0, 1'b1, 4'd7);
    chk("r7_set_wins", {31'd0, bus.busy[7]}, 32'd1);
    cyc(1'b0, 4'd0, 19'd0, 1'b1, 4'd7, 19'h07071, 1'b0, 4'd0);
    idle();

    // Reset with two entries queued and r6/r7 busy.
    cyc(1'b0, 4'd0, 19'd0, 1'b0, 4'd0, 19'd0, 1'b1, 4'd6);
    cyc(1'b0, 4'd0, 19'd0, 1'b0, 4'd0, 19'd0, 1'b1, 4'd7);
    cyc(1'b1, 4'd4, 19'h00444, 1'b1, 4'd6, 19'h66666, 1'b0, 4'd0);
    cyc(1'b1, 4'd4, 19'h00445, 1'b1, 4'd7, 19'h77777, 1'b0, 4'd0);
    chk("pre_rst_busy", {16'd0, bus.busy}, 32'h00C0);
    #3;
    reset = 1'b1;
    #1;
    model_clear();
    chk("async_rst_we", {31'd0, bus.rf_regwrite}, 32'd0);
    chk("async_rst_busy", {16'd0, bus.busy}, 32'd0);
    chk("async_rst_ready", {31'd0, bus.long_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) idle();

    // Random traffic; issue only to registers the model says are free.
    for (int i = 0; i < 400; i++) begin
      ir = 4'($urandom_range(0, 15));
      il = ($urandom_range(0, 3) == 0) && !m_busy[ir];
      cyc(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), 19'($urandom),
          ($urandom_range(0, 1) == 0), 4'($urandom_range(0, 15)), 19'($urandom),
          il, ir);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
